// File: rtl/mem_dump_sequencer_pkg.sv
// Shared constants and state encoding for the data-memory dump sequencer.
// Imported by the interface, the serializer and the top-level FSM.
package mem_dump_sequencer_pkg;

  localparam int ADDRWIDTH = 5;

  typedef enum logic [2:0] {
    DUMP_IDLE      = 3'd0,
    DUMP_REQ       = 3'd1,
    DUMP_WAIT_RD   = 3'd2,
    DUMP_SEND      = 3'd3,
    DUMP_WAIT_TX   = 3'd4,
    DUMP_NEXT_BYTE = 3'd5,
    DUMP_NEXT_WORD = 3'd6,
    DUMP_DONE      = 3'd7
  } dump_state_t;

endpackage

// File: rtl/mem_dump_sequencer_if.sv
// Bundle between the dump sequencer and the memory stage / UART TX.
// master = sequencer side, slave = memory stage, UART and debug control.
interface mem_dump_sequencer_if #(
  parameter int NB_DATA = 32
);
  import mem_dump_sequencer_pkg::*;

  logic                 i_start;
  logic                 i_pipeline_halted;
  logic [NB_DATA-1:0]   i_mem_data;
  logic                 i_tx_done;
  logic [ADDRWIDTH-1:0] o_addr_mem_debug_unit;
  logic                 o_ctrl_addr_debug_mem;
  logic                 o_ctrl_wr_debug_mem;
  logic                 o_read_du;
  logic                 o_enable_mem;
  logic [7:0]           o_tx_data;
  logic                 o_tx_start;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    input  i_start, i_pipeline_halted,
    input  i_mem_data, i_tx_done,
    output o_addr_mem_debug_unit,
    output o_ctrl_addr_debug_mem,
    output o_ctrl_wr_debug_mem,
    output o_read_du, o_enable_mem,
    output o_tx_data, o_tx_start,
    output o_busy, o_done
  );

  modport slave (
    output i_start, i_pipeline_halted,
    output i_mem_data, i_tx_done,
    input  o_addr_mem_debug_unit,
    input  o_ctrl_addr_debug_mem,
    input  o_ctrl_wr_debug_mem,
    input  o_read_du, o_enable_mem,
    input  o_tx_data, o_tx_start,
    input  o_busy, o_done
  );

endinterface

// File: rtl/mem_dump_sequencer_serializer.sv
// Word-to-byte serializer: loads a word, presents bytes MSB-first,
// advances on each shift and flags the last byte of the word.
module word_byte_serializer #(
  parameter int NB_DATA = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  input  logic               i_shift,
  output logic [7:0]         o_byte,
  output logic               o_last_byte
);

  localparam int NB_BYTES = NB_DATA / 8;
  localparam int BW = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  logic [NB_DATA-1:0] shreg;
  logic [BW-1:0]      byte_cnt;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (i_load) begin
      shreg    <= i_word;
      byte_cnt <= '0;
    end else if (i_shift) begin
      shreg    <= {shreg[NB_DATA-9:0], 8'h00};
      byte_cnt <= byte_cnt + BW'(1);
    end
  end

  assign o_byte      = shreg[NB_DATA-1 -: 8];
  assign o_last_byte = (byte_cnt == BW'(NB_BYTES - 1));

endmodule

// File: rtl/mem_dump_sequencer.sv
// Post-halt data-memory dump: reads each word through the debug port of
// the memory stage and streams its bytes MSB-first to the UART TX.
module mem_dump_sequencer
  import mem_dump_sequencer_pkg::*;
#(
  parameter int NB_DATA      = 32,
  parameter int N_WORDS      = 32,
  parameter int ADDR_STEP    = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  mem_dump_sequencer_if.master bus
);

  localparam int LW  = $clog2(READ_LATENCY + 1);
  localparam int WCW = ADDRWIDTH + 1;

  dump_state_t          state;
  logic [LW-1:0]        lat_cnt;
  logic [WCW-1:0]       word_cnt;
  logic [ADDRWIDTH-1:0] addr;
  logic                 sel;
  logic                 tx_start;
  logic                 busy;
  logic                 done;
  logic                 load;
  logic                 shift;
  logic                 last_byte;
  logic [7:0]           tx_byte;

  // Word is sampled on the READ_LATENCY-th cycle after REQ entry.
  assign load  = (state == DUMP_WAIT_RD) &&
                 (lat_cnt == LW'(READ_LATENCY));
  assign shift = (state == DUMP_WAIT_TX) && bus.i_tx_done;

  word_byte_serializer #(
    .NB_DATA (NB_DATA)
  ) u_ser (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_load      (load),
    .i_word      (bus.i_mem_data),
    .i_shift     (shift),
    .o_byte      (tx_byte),
    .o_last_byte (last_byte)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state    <= DUMP_IDLE;
      lat_cnt  <= '0;
      word_cnt <= '0;
      addr     <= '0;
      sel      <= 1'b0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        DUMP_IDLE: begin
          if (bus.i_start && bus.i_pipeline_halted) begin
            addr     <= '0;
            word_cnt <= '0;
            lat_cnt  <= '0;
            busy     <= 1'b1;
            sel      <= 1'b1;
            state    <= DUMP_REQ;
          end
        end
        DUMP_REQ: begin
          lat_cnt <= LW'(1);
          state   <= DUMP_WAIT_RD;
        end
        DUMP_WAIT_RD: begin
          if (load) begin
            sel      <= 1'b0;
            tx_start <= 1'b1;
            state    <= DUMP_SEND;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        DUMP_SEND: begin
          tx_start <= 1'b0;
          state    <= DUMP_WAIT_TX;
        end
        DUMP_WAIT_TX: begin
          if (bus.i_tx_done) begin
            if (last_byte) begin
              word_cnt <= word_cnt + WCW'(1);
              addr     <= addr + ADDRWIDTH'(ADDR_STEP);
              state    <= DUMP_NEXT_WORD;
            end else begin
              state <= DUMP_NEXT_BYTE;
            end
          end
        end
        DUMP_NEXT_BYTE: begin
          tx_start <= 1'b1;
          state    <= DUMP_SEND;
        end
        DUMP_NEXT_WORD: begin
          if (word_cnt == WCW'(N_WORDS)) begin
            done  <= 1'b1;
            state <= DUMP_DONE;
          end else begin
            lat_cnt <= '0;
            sel     <= 1'b1;
            state   <= DUMP_REQ;
          end
        end
        DUMP_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= DUMP_IDLE;
        end
      endcase
    end
  end

  assign bus.o_addr_mem_debug_unit = addr;
  assign bus.o_ctrl_addr_debug_mem = sel;
  assign bus.o_ctrl_wr_debug_mem   = sel;
  assign bus.o_read_du             = sel;
  assign bus.o_enable_mem          = sel;
  assign bus.o_tx_data             = tx_byte;
  assign bus.o_tx_start            = tx_start;
  assign bus.o_busy                = busy;
  assign bus.o_done                = done;

endmodule

// File: tb/tb_mem_dump_sequencer.sv
// Directed bench: a 2-word and a 32-word sequencer share clock and reset,
// each with a latency-2 memory model and a 10-cycle UART TX model.
module tb_mem_dump_sequencer;
  import mem_dump_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_dump_sequencer_if #(.NB_DATA(32)) b2 ();
  mem_dump_sequencer_if #(.NB_DATA(32)) b32 ();

  mem_dump_sequencer #(.N_WORDS(2)) dut2 (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (b2.master)
  );

  mem_dump_sequencer #(.N_WORDS(32)) dut32 (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (b32.master)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] mem2 [2];
  logic [7:0]  exp2 [8];
  logic [7:0]  q2[$], q32[$];
  int          a2[$], a32[$], s2[$], s32[$];
  int          d2 = 0, d32 = 0;
  int          rc2 = 0, rc32 = 0, tc2 = 0, tc32 = 0;
  logic        md2 = 1'b0, md32 = 1'b0;
  logic        stray2 = 1'b0, stray32 = 1'b0;

  assign b2.i_tx_done  = md2 | stray2;
  assign b32.i_tx_done = md32 | stray32;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor + memory model + TX model for the 2-word instance.
  always @(negedge clk) begin
    if (b2.o_tx_start) q2.push_back(b2.o_tx_data);
    if (b2.o_done) d2++;
    if (b2.o_read_du) begin
      if (rc2 == 0) a2.push_back(int'(b2.o_addr_mem_debug_unit));
      rc2++;
    end else begin
      if (rc2 != 0) s2.push_back(rc2);
      rc2 = 0;
    end
    b2.i_mem_data = (b2.o_read_du && rc2 == 3) ?
                    mem2[b2.o_addr_mem_debug_unit[0]] : $urandom;
    md2 = 1'b0;
    if (tc2 != 0) begin
      tc2--;
      if (tc2 == 0) md2 = 1'b1;
    end
    if (b2.o_tx_start) tc2 = 10;
    if (!rst_n) tc2 = 0;
  end

  // Same for the 32-word instance; mem[a] = {4{a}} byte-wise.
  always @(negedge clk) begin
    if (b32.o_tx_start) q32.push_back(b32.o_tx_data);
    if (b32.o_done) d32++;
    if (b32.o_read_du) begin
      if (rc32 == 0) a32.push_back(int'(b32.o_addr_mem_debug_unit));
      rc32++;
    end else begin
      if (rc32 != 0) s32.push_back(rc32);
      rc32 = 0;
    end
    b32.i_mem_data = (b32.o_read_du && rc32 == 3) ?
                     {4{3'b000, b32.o_addr_mem_debug_unit}} : $urandom;
    md32 = 1'b0;
    if (tc32 != 0) begin
      tc32--;
      if (tc32 == 0) md32 = 1'b1;
    end
    if (b32.o_tx_start) tc32 = 10;
    if (!rst_n) tc32 = 0;
  end

  task automatic chk_idle2(input string tag);
    chk({tag, "_addr"}, 32'(b2.o_addr_mem_debug_unit), 0);
    chk({tag, "_sel"}, {28'd0, b2.o_ctrl_addr_debug_mem,
        b2.o_ctrl_wr_debug_mem, b2.o_read_du, b2.o_enable_mem}, 0);
    chk({tag, "_txdata"}, 32'(b2.o_tx_data), 0);
    chk({tag, "_txstart"}, 32'(b2.o_tx_start), 0);
    chk({tag, "_busy"}, 32'(b2.o_busy), 0);
    chk({tag, "_done"}, 32'(b2.o_done), 0);
  endtask

  initial begin
    int base, abase, bad;
    mem2[0] = 32'h1122_3344;
    mem2[1] = 32'hA5A5_0001;
    exp2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'hA5, 8'h00, 8'h01};
    b2.i_start = 1'b1;
    b32.i_start = 1'b1;
    b2.i_pipeline_halted = 1'b1;
    b32.i_pipeline_halted = 1'b0;

    // Reset held with start asserted
    repeat (3) @(negedge clk);
    chk_idle2("t1");
    chk("t1_no_tx", 32'(q2.size()), 0);
    rst_n = 1'b1;
    b2.i_start = 1'b0;
    b32.i_start = 1'b0;

    // Start without halt is dropped
    b2.i_pipeline_halted = 1'b0;
    @(negedge clk) b2.i_start = 1'b1;
    @(negedge clk) b2.i_start = 1'b0;
    b2.i_pipeline_halted = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_nohalt_busy", 32'(b2.o_busy), 0);
    chk("t4_nohalt_rd", 32'(b2.o_read_du), 0);

    // Two-word dump with restart and stray tx_done in REQ
    b2.i_start = 1'b1;
    @(negedge clk);
    chk("t2_busy", 32'(b2.o_busy), 1);
    chk("t2_req_rd", 32'(b2.o_read_du), 1);
    stray2 = 1'b1;
    @(negedge clk);
    b2.i_start = 1'b0;
    stray2 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (b2.o_done) break;
      @(negedge clk);
    end
    chk("t2_done_seen", 32'(b2.o_done), 1);
    chk("t2_nbytes", 32'(q2.size()), 8);
    for (int i = 0; i < 8 && i < q2.size(); i++)
      chk($sformatf("t2_byte%0d", i), 32'(q2[i]), 32'(exp2[i]));
    chk("t2_naddr", 32'(a2.size()), 2);
    if (a2.size() == 2) begin
      chk("t2_addr0", 32'(a2[0]), 0);
      chk("t2_addr1", 32'(a2[1]), 1);
    end
    chk("t3_nstrobe", 32'(s2.size()), 2);
    for (int i = 0; i < s2.size(); i++)
      chk($sformatf("t3_strobe%0d", i), 32'(s2[i]), 3);
    @(negedge clk);
    chk("t2_busy_drop", 32'(b2.o_busy), 0);
    chk("t2_done_pulse", 32'(b2.o_done), 0);
    chk("t2_done_count", 32'(d2), 1);

    // Reset during WAIT_TX of byte 3, then a clean dump
    base = q2.size();
    b2.i_start = 1'b1;
    @(negedge clk) b2.i_start = 1'b0;
    for (int i = 0; i < 200 && q2.size() < base + 3; i++)
      @(negedge clk);
    chk("t6_reached_b3", 32'(q2.size()), 32'(base + 3));
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    chk_idle2("t6_rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    base = q2.size();
    abase = a2.size();
    b2.i_start = 1'b1;
    @(negedge clk) b2.i_start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (b2.o_done) break;
      @(negedge clk);
    end
    chk("t6_done_seen", 32'(b2.o_done), 1);
    chk("t6_nbytes", 32'(q2.size() - base), 8);
    bad = 0;
    for (int i = 0; i < 8 && base + i < q2.size(); i++)
      if (q2[base + i] !== exp2[i]) bad++;
    chk("t6_bytes_bad", 32'(bad), 0);
    if (a2.size() > abase) chk("t6_addr0", 32'(a2[abase]), 0);
    else chk("t6_addr_seen", 32'(a2.size()), 32'(abase + 1));

    // Full 32-word dump, address wrap, restart at 0
    b32.i_pipeline_halted = 1'b1;
    b32.i_start = 1'b1;
    @(negedge clk) b32.i_start = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (b32.o_done) break;
      @(negedge clk);
    end
    chk("t5_done_seen", 32'(b32.o_done), 1);
    chk("t5_naddr", 32'(a32.size()), 32);
    bad = 0;
    for (int i = 0; i < a32.size(); i++)
      if (a32[i] != i) bad++;
    chk("t5_addr_bad", 32'(bad), 0);
    chk("t5_nbytes", 32'(q32.size()), 128);
    bad = 0;
    for (int i = 0; i < q32.size(); i++)
      if (q32[i] !== 8'(i / 4)) bad++;
    chk("t5_bytes_bad", 32'(bad), 0);
    @(negedge clk);
    chk("t5_done_count", 32'(d32), 1);
    b32.i_start = 1'b1;
    @(negedge clk) b32.i_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (b32.o_read_du) break;
      @(negedge clk);
    end
    chk("t5_restart_rd", 32'(b32.o_read_du), 1);
    chk("t5_restart_addr", 32'(b32.o_addr_mem_debug_unit), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
